fetch_unit: RTL and testbench

//  Instruction fetch stage of the RISC-V core; owns the PC.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: datapath widths, reset vector and the fetch->decode entry payload.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t with push/pop/flush and occupancy count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop, full;
    fetch_entry_t  mem_q [DEPTH];

    always_comb begin
        do_pop  = pop && (count_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (do_pop) rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= push_data;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rptr_q];

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests,
// buffers responses for decode and applies branch/JAL/JALR redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            redirect_valid,
    input  logic            redirect_jalr,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] redirect_rs1,
    input  logic [XLEN-1:0] redirect_imm,
    output logic            redirect_misaligned
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
    logic            misal_q, misal_d;
    logic [CW-1:0]   fifo_count;
    logic [CW1-1:0]  credit_used;
    logic            fifo_empty, push, pop, fire;
    logic [XLEN-1:0] base, sum, target;
    fetch_entry_t    push_entry, head;

    // Requests are throttled so in-flight plus buffered words never exceed the FIFO.
    assign credit_used    = {1'b0, out_q} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < CW1'(FIFO_DEPTH));
    assign imem_addr      = pc_q;

    always_comb begin
        fire       = imem_req_valid && imem_req_ready;
        pop        = instr_valid && instr_ready;
        base       = redirect_jalr ? redirect_rs1 : redirect_pc;
        sum        = base + redirect_imm;
        target     = sum;
        if (redirect_jalr) target[0] = 1'b0;
        target[1]  = 1'b0;

        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        misal_d    = 1'b0;
        push       = 1'b0;
        push_entry = '{instr: imem_rsp_data, pc: resp_pc_q};

        if (redirect_valid) begin
            // Every response still owed by memory belongs to the old path.
            pc_d      = target;
            resp_pc_d = target;
            misal_d   = sum[1];
            out_d     = out_q - CW'(imem_rsp_valid);
            drop_d    = out_q - CW'(imem_rsp_valid);
        end else begin
            out_d = out_q + CW'(fire) - CW'(imem_rsp_valid);
            if (fire) pc_d = pc_q + XLEN'(4);
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            resp_pc_q <= RESET_VECTOR;
            out_q     <= '0;
            drop_q    <= '0;
            misal_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            misal_q   <= misal_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid         = !fifo_empty;
    assign instr               = instr_valid ? head.instr : '0;
    assign instr_pc            = instr_valid ? head.pc : '0;
    assign instr_pc_plus4      = instr_valid ? head.pc + XLEN'(4) : '0;
    assign redirect_misaligned = misal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pc_plus4;
    logic        redirect_valid, redirect_jalr;
    logic [31:0] redirect_pc, redirect_rs1, redirect_imm;
    logic        redirect_misaligned;
    logic        mem_hold;

    int n_checks = 0;
    int n_fail   = 0;
    int fire_cnt = 0;
    int fire_base;

    logic [31:0] mem_q [$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_req_valid      (imem_req_valid),
        .imem_req_ready      (imem_req_ready),
        .imem_addr           (imem_addr),
        .imem_rsp_valid      (imem_rsp_valid),
        .imem_rsp_data       (imem_rsp_data),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr               (instr),
        .instr_pc            (instr_pc),
        .instr_pc_plus4      (instr_pc_plus4),
        .redirect_valid      (redirect_valid),
        .redirect_jalr       (redirect_jalr),
        .redirect_pc         (redirect_pc),
        .redirect_rs1        (redirect_rs1),
        .redirect_imm        (redirect_imm),
        .redirect_misaligned (redirect_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One-cycle in-order memory; mem_hold stalls responses to build up in-flight requests.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_addr);
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(mem_q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && imem_req_valid && imem_req_ready) fire_cnt <= fire_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redirect(input logic jalr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] imm);
        redirect_valid = 1'b1;
        redirect_jalr  = jalr;
        redirect_pc    = pc;
        redirect_rs1   = rs1;
        redirect_imm   = imm;
    endtask

    task automatic clear_redirect();
        redirect_valid = 1'b0;
        redirect_jalr  = 1'b0;
    endtask

    task automatic do_reset();
        clear_redirect();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_hold       = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fire_base = fire_cnt;
    endtask

    task automatic wait_instr(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            tick();
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_redirect();
        redirect_pc    = '0;
        redirect_rs1   = '0;
        redirect_imm   = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_hold       = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_misal", 32'(redirect_misaligned), 32'd0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Streaming fetch with 1-cycle memory
        @(negedge clk);
        reset = 1'b0;
        fire_base = fire_cnt;
        #1;
        check("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        tick();
        check("t1_addr1", imem_addr, 32'h4);
        tick();
        check("t1_valid0", 32'(instr_valid), 32'd1);
        check("t1_pc0", instr_pc, 32'h0);
        check("t1_instr0", instr, mem_word(32'h0));
        check("t1_plus4_0", instr_pc_plus4, 32'h4);
        tick();
        check("t1_pc1", instr_pc, 32'h4);
        check("t1_instr1", instr, mem_word(32'h4));
        tick();
        check("t1_pc2", instr_pc, 32'h8);
        check("t1_plus4_2", instr_pc_plus4, 32'hC);

        // Credit limit with decode stalled
        do_reset();
        instr_ready = 1'b0;
        repeat (10) tick();
        check("t2_fires", 32'(fire_cnt - fire_base), 32'd4);
        check("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
        check("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        check("t2_head_after_pop", instr_pc, 32'h4);
        check("t2_req_valid_credit", 32'(imem_req_valid), 32'd1);
        repeat (6) tick();
        check("t2_fires_after_pop", 32'(fire_cnt - fire_base), 32'd5);
        check("t2_req_valid_refull", 32'(imem_req_valid), 32'd0);

        // Branch redirect with two stale responses in flight
        do_reset();
        mem_hold = 1'b1;
        tick();
        tick();
        check("t3_inflight", 32'(fire_cnt - fire_base), 32'd2);
        set_redirect(1'b0, 32'h100, 32'h0, 32'hFFFF_FFF0);
        #1;
        check("t3_no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        clear_redirect();
        mem_hold = 1'b0;
        #1;
        check("t3_addr", imem_addr, 32'hF0);
        check("t3_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_flushed", 32'(instr_valid), 32'd0);
        wait_instr("t3_wait");
        check("t3_pc", instr_pc, 32'hF0);
        check("t3_instr", instr, mem_word(32'hF0));
        tick();
        check("t3_pc_next", instr_pc, 32'hF4);
        check("t3_instr_next", instr, mem_word(32'hF4));

        // Target formation, bit clearing and misaligned pulse
        do_reset();
        mem_hold = 1'b1;
        set_redirect(1'b1, 32'h0, 32'h203, 32'h1);
        tick();
        check("t4_jalr_addr", imem_addr, 32'h204);
        check("t4_jalr_misal", 32'(redirect_misaligned), 32'd0);
        set_redirect(1'b1, 32'h0, 32'h200, 32'h2);
        tick();
        check("t4_mis_addr", imem_addr, 32'h200);
        check("t4_mis_pulse", 32'(redirect_misaligned), 32'd1);
        set_redirect(1'b0, 32'h100, 32'h0, 32'h6);
        tick();
        check("t4_br_mis_addr", imem_addr, 32'h104);
        check("t4_br_mis_pulse", 32'(redirect_misaligned), 32'd1);
        set_redirect(1'b1, 32'h0, 32'h201, 32'h0);
        tick();
        check("t4_jalr_bit0", imem_addr, 32'h200);
        check("t4_jalr_bit0_misal", 32'(redirect_misaligned), 32'd0);
        clear_redirect();
        tick();
        check("t4_misal_low", 32'(redirect_misaligned), 32'd0);
        check("t4_fetch_after", imem_addr, 32'h204);

        // Redirect coincident with a response and a decode pop
        do_reset();
        tick();
        tick();
        check("t5_pre_valid", 32'(instr_valid), 32'd1);
        check("t5_pre_pc", instr_pc, 32'h0);
        set_redirect(1'b0, 32'h300, 32'h0, 32'h0);
        #1;
        check("t5_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        clear_redirect();
        #1;
        check("t5_empty", 32'(instr_valid), 32'd0);
        check("t5_addr", imem_addr, 32'h300);
        wait_instr("t5_wait");
        check("t5_pc", instr_pc, 32'h300);
        check("t5_instr", instr, mem_word(32'h300));

        // PC and target wrap-around
        do_reset();
        mem_hold = 1'b1;
        set_redirect(1'b0, 32'hFFFF_FFF0, 32'h0, 32'hC);
        tick();
        clear_redirect();
        #1;
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("t6_pc_wrap", imem_addr, 32'h0);
        set_redirect(1'b0, 32'hFFFF_FFF8, 32'h0, 32'h10);
        tick();
        clear_redirect();
        #1;
        check("t6_target_wrap", imem_addr, 32'h8);

        // Asynchronous reset while draining stale responses
        do_reset();
        mem_hold = 1'b1;
        tick();
        tick();
        set_redirect(1'b0, 32'h400, 32'h0, 32'h0);
        tick();
        clear_redirect();
        tick();
        check("t7_draining_addr", imem_addr, 32'h404);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_addr", imem_addr, 32'h0);
        check("t7_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t7_rst_instr_valid", 32'(instr_valid), 32'd0);
        check("t7_rst_misal", 32'(redirect_misaligned), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        mem_hold = 1'b0;
        wait_instr("t7_wait");
        check("t7_pc", instr_pc, 32'h0);
        check("t7_instr", instr, mem_word(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
